// File: rtl/ex2_mean_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex2_mean_pkg
// Purpose  : Shared definitions for the E[x^2] mean unit: default widths,
//            FSM state type and encodings, accumulator width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ex2_mean_pkg;

  localparam int DEF_DATA_W   = 9;
  localparam int DEF_OUT_W    = 8;
  localparam int DEF_INV_W    = 8;
  localparam int DEF_INV_FRAC = 8;
  localparam int DEF_MAX_LEN  = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_SCALE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Room for MAX_LEN full-scale squares plus a sign bit.
  function automatic int acc_width(input int data_w, input int max_len);
    return 2 * data_w + $clog2(max_len) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex2_scale_sat.sv
`default_nettype none
// ============================================================================
// Module   : ex2_scale_sat
// Purpose  : Multiplies an accumulator by the unsigned Q0.INV_FRAC reciprocal,
//            shifts out the fraction (arithmetic shift, i.e. floor) and
//            saturates to an unsigned or signed OUT_W result.
// Ports    : i_val  [IN_W]   accumulator (signed when SIGNED=1)
//            i_inv  [INV_W]  reciprocal length, unsigned
//            o_res  [OUT_W]  scaled, saturated result
//            o_sat           result was clamped
// Revision : 1.0 - initial release
// ============================================================================
module ex2_scale_sat #(
  parameter int IN_W     = 25,
  parameter int INV_W    = 8,
  parameter int INV_FRAC = 8,
  parameter int OUT_W    = 8,
  parameter bit SIGNED   = 1'b0
) (
  input  logic [IN_W-1:0]  i_val,
  input  logic [INV_W-1:0] i_inv,
  output logic [OUT_W-1:0] o_res,
  output logic             o_sat
);

  // One extra bit keeps the product of an unsigned operand pair non-negative.
  localparam int PW = IN_W + INV_W + 1;

  logic signed [PW-1:0] val_ext;
  logic signed [PW-1:0] inv_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  assign inv_ext = {{(PW-INV_W){1'b0}}, i_inv};
  assign prod    = val_ext * inv_ext;
  assign shifted = prod >>> INV_FRAC;

  generate
    if (SIGNED) begin : g_signed
      localparam logic signed [PW-1:0] C_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [PW-1:0] C_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

      assign val_ext = {{(PW-IN_W){i_val[IN_W-1]}}, i_val};

      always_comb begin
        o_sat = 1'b0;
        o_res = shifted[OUT_W-1:0];
        if (shifted > C_MAX) begin
          o_sat = 1'b1;
          o_res = C_MAX[OUT_W-1:0];
        end else if (shifted < C_MIN) begin
          o_sat = 1'b1;
          o_res = C_MIN[OUT_W-1:0];
        end
      end
    end else begin : g_unsigned
      localparam logic signed [PW-1:0] C_MAX = {{(PW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

      assign val_ext = {{(PW-IN_W){1'b0}}, i_val};

      always_comb begin
        o_sat = 1'b0;
        o_res = shifted[OUT_W-1:0];
        if (shifted > C_MAX) begin
          o_sat = 1'b1;
          o_res = C_MAX[OUT_W-1:0];
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ex2_mean_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex2_mean_unit
// Purpose  : Streams a vector of signed samples, accumulates compressed
//            squares (x*x >> 2*alpha) and, optionally, the raw samples, then
//            scales by the reciprocal length to give E[x^2] (and E[x]).
// Ports    : i_clk, i_rst (sync, active high)
//            i_valid/o_ready, i_x, i_last, i_alpha, i_inv_n  - sample input
//            o_valid/i_ready, o_ex2, o_ovf, o_ex             - result output
// Macro    : EX2_MEAN_EX_EN - adds o_ex, the sum-of-x accumulator and the
//            signed mean path.
// Revision : 1.0 - initial release
// ============================================================================
module ex2_mean_unit
  import ex2_mean_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int INV_W    = DEF_INV_W,
  parameter int INV_FRAC = DEF_INV_FRAC,
  parameter int MAX_LEN  = DEF_MAX_LEN
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_x,
  input  logic              i_last,
  input  logic [1:0]        i_alpha,
  input  logic [INV_W-1:0]  i_inv_n,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_ex2,
  output logic              o_ovf
`ifdef EX2_MEAN_EX_EN
  ,
  output logic [OUT_W-1:0]  o_ex
`endif
);

  localparam int ACC_W = acc_width(DATA_W, MAX_LEN);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         alpha_q, alpha_d;
  logic [INV_W-1:0]   inv_q, inv_d;
  logic [ACC_W-1:0]   sum_sq_q, sum_sq_d;
  logic [OUT_W-1:0]   ex2_q, ex2_d;
  logic               ovf_q, ovf_d;

  logic                      accept;
  logic                      first;
  logic                      is_last;
  logic [1:0]                alpha_eff;
  logic [CNT_W-1:0]          cnt_cur;
  logic signed [2*DATA_W-1:0] x_ext;
  logic signed [2*DATA_W-1:0] sq_s;
  logic [2*DATA_W-1:0]       sq_sh;
  logic [ACC_W-1:0]          sq_acc;
  logic [OUT_W-1:0]          ex2_res;
  logic                      ex2_sat;

`ifdef EX2_MEAN_EX_EN
  logic signed [ACC_W-1:0] sum_x_q, sum_x_d;
  logic [OUT_W-1:0]        ex_q, ex_d;
  logic [ACC_W-1:0]        x_acc;
  logic [OUT_W-1:0]        ex_res;
  logic                    ex_sat;
`endif

  assign o_ready = !i_rst && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
  assign accept  = i_valid && o_ready;
  assign first   = (state_q == ST_IDLE);

  // The first sample of a vector must use the live operands since they are
  // only being latched on that same edge.
  assign alpha_eff = first ? i_alpha : alpha_q;
  // The count register is stale in IDLE (left over from the previous vector).
  assign cnt_cur   = first ? '0 : count_q;
  assign is_last   = i_last || (cnt_cur == CNT_W'(MAX_LEN - 1));

  assign x_ext  = {{DATA_W{i_x[DATA_W-1]}}, i_x};
  assign sq_s   = x_ext * x_ext;
  assign sq_sh  = $unsigned(sq_s) >> {alpha_eff, 1'b0};
  assign sq_acc = {{(ACC_W-2*DATA_W){1'b0}}, sq_sh};

  ex2_scale_sat #(
    .IN_W     (ACC_W),
    .INV_W    (INV_W),
    .INV_FRAC (INV_FRAC),
    .OUT_W    (OUT_W),
    .SIGNED   (1'b0)
  ) u_scale_ex2 (
    .i_val (sum_sq_q),
    .i_inv (inv_q),
    .o_res (ex2_res),
    .o_sat (ex2_sat)
  );

`ifdef EX2_MEAN_EX_EN
  assign x_acc = {{(ACC_W-DATA_W){i_x[DATA_W-1]}}, i_x};

  ex2_scale_sat #(
    .IN_W     (ACC_W),
    .INV_W    (INV_W),
    .INV_FRAC (INV_FRAC),
    .OUT_W    (OUT_W),
    .SIGNED   (1'b1)
  ) u_scale_ex (
    .i_val (sum_x_q),
    .i_inv (inv_q),
    .o_res (ex_res),
    .o_sat (ex_sat)
  );

  assign o_ex = ex_q;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    alpha_d  = alpha_q;
    inv_d    = inv_q;
    sum_sq_d = sum_sq_q;
    ex2_d    = ex2_q;
    ovf_d    = ovf_q;
`ifdef EX2_MEAN_EX_EN
    sum_x_d  = sum_x_q;
    ex_d     = ex_q;
`endif

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          if (first) begin
            alpha_d  = i_alpha;
            inv_d    = i_inv_n;
            sum_sq_d = sq_acc;
            ovf_d    = 1'b0;
`ifdef EX2_MEAN_EX_EN
            sum_x_d  = x_acc;
`endif
          end else begin
            sum_sq_d = sum_sq_q + sq_acc;
`ifdef EX2_MEAN_EX_EN
            sum_x_d  = sum_x_q + x_acc;
`endif
          end
          count_d = cnt_cur + CNT_W'(1);
          state_d = is_last ? ST_SCALE : ST_ACCUM;
        end
      end
      ST_SCALE: begin
        ex2_d   = ex2_res;
`ifdef EX2_MEAN_EX_EN
        ex_d    = ex_res;
        ovf_d   = ex2_sat | ex_sat;
`else
        ovf_d   = ex2_sat;
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      alpha_q  <= '0;
      inv_q    <= '0;
      sum_sq_q <= '0;
      ex2_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef EX2_MEAN_EX_EN
      sum_x_q  <= '0;
      ex_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      alpha_q  <= alpha_d;
      inv_q    <= inv_d;
      sum_sq_q <= sum_sq_d;
      ex2_q    <= ex2_d;
      ovf_q    <= ovf_d;
`ifdef EX2_MEAN_EX_EN
      sum_x_q  <= sum_x_d;
      ex_q     <= ex_d;
`endif
    end
  end

  assign o_valid = (state_q == ST_DONE);
  assign o_ex2   = ex2_q;
  assign o_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ex2_mean_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex2_mean_unit
// Purpose  : Self-checking bench for ex2_mean_unit. A per-cycle monitor
//            compares the DUT against an arithmetic model of the vector mean;
//            directed vectors pin hand-computed results and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex2_mean_unit;

  localparam int DATA_W   = 9;
  localparam int OUT_W    = 8;
  localparam int INV_W    = 8;
  localparam int INV_FRAC = 8;
  localparam int MAX_LEN  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_x;
  logic              i_last;
  logic [1:0]        i_alpha;
  logic [INV_W-1:0]  i_inv_n;
  logic              o_valid;
  logic              i_ready;
  logic [OUT_W-1:0]  o_ex2;
  logic              o_ovf;
`ifdef EX2_MEAN_EX_EN
  logic [OUT_W-1:0]  o_ex;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex2_mean_unit #(
    .DATA_W   (DATA_W),
    .OUT_W    (OUT_W),
    .INV_W    (INV_W),
    .INV_FRAC (INV_FRAC),
    .MAX_LEN  (MAX_LEN)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .i_last  (i_last),
    .i_alpha (i_alpha),
    .i_inv_n (i_inv_n),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_ex2   (o_ex2),
    .o_ovf   (o_ovf)
`ifdef EX2_MEAN_EX_EN
    ,
    .o_ex    (o_ex)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: collects the accepted samples of a vector as running
  // sums, and when the vector closes computes the means with plain integer
  // arithmetic. The result appears two cycles after the cycle in which the
  // closing sample is presented and stays until the consumer takes it.
  // --------------------------------------------------------------------------
  bit     mon_en  = 1'b0;
  bit     m_ready = 1'b1;
  bit     m_valid = 1'b0;
  bit     m_delay = 1'b0;
  int     m_n     = 0;
  int     m_alpha = 0;
  int     m_inv   = 0;
  longint m_sq    = 0;
  longint m_sx    = 0;
  longint e_ex2   = 0;
  longint e_ex    = 0;
  bit     e_ovf   = 1'b0;

  initial begin
    longint xv;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("mon_ready", longint'(o_ready), longint'(!rst && m_ready));
        chk("mon_valid", longint'(o_valid), longint'(m_valid));
        if (m_valid) begin
          chk("mon_ex2", longint'(o_ex2), e_ex2);
          chk("mon_ovf", longint'(o_ovf), longint'(e_ovf));
`ifdef EX2_MEAN_EX_EN
          chk("mon_ex", longint'($signed(o_ex)), e_ex);
`endif
        end
        // advance the model across the coming rising edge
        if (rst) begin
          m_ready = 1'b1; m_valid = 1'b0; m_delay = 1'b0; m_n = 0;
        end else if (m_valid) begin
          if (i_ready) begin
            m_valid = 1'b0; m_ready = 1'b1;
          end
        end else if (m_delay) begin
          m_delay = 1'b0; m_valid = 1'b1;
        end else if (m_ready && i_valid) begin
          if (m_n == 0) begin
            m_alpha = int'(i_alpha); m_inv = int'(i_inv_n); m_sq = 0; m_sx = 0;
          end
          xv = longint'($signed(i_x));
          m_sq += (xv * xv) >> (2 * m_alpha);
          m_sx += xv;
          m_n++;
          if (i_last || m_n == MAX_LEN) begin
            e_ovf = 1'b0;
            e_ex2 = (m_sq * m_inv) >>> INV_FRAC;
            if (e_ex2 > (2**OUT_W) - 1) begin e_ex2 = (2**OUT_W) - 1; e_ovf = 1'b1; end
            e_ex = (m_sx * m_inv) >>> INV_FRAC;
            if (e_ex > (2**(OUT_W-1)) - 1) begin
              e_ex = (2**(OUT_W-1)) - 1;
`ifdef EX2_MEAN_EX_EN
              e_ovf = 1'b1;
`endif
            end else if (e_ex < -(2**(OUT_W-1))) begin
              e_ex = -(2**(OUT_W-1));
`ifdef EX2_MEAN_EX_EN
              e_ovf = 1'b1;
`endif
            end
            m_ready = 1'b0; m_delay = 1'b1; m_n = 0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic send(input int x, input bit last, input int a, input int inv);
    i_valid = 1'b1;
    i_x     = x[DATA_W-1:0];
    i_last  = last;
    i_alpha = a[1:0];
    i_inv_n = inv[INV_W-1:0];
    @(posedge clk); #1;
  endtask

  task automatic drop();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic ramp(input int a, input int inv);
    for (int i = 1; i <= 16; i++) send(i, (i == 16), a, inv);
    drop();
  endtask

  // Cycle 0 is the cycle in which the closing sample is presented; returns
  // the cycle number in which o_valid is first seen.
  task automatic wait_res(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_valid && lat < 40);
    if (!o_valid) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic consume();
    @(posedge clk); #1;
  endtask

  task automatic check_res(input string name, input int lat, input int ex2,
                           input int ex, input bit ovf);
    chk({name, "_latency"}, lat, 2);
    chk({name, "_ex2"}, longint'(o_ex2), ex2);
    chk({name, "_ovf"}, longint'(o_ovf), longint'(ovf));
`ifdef EX2_MEAN_EX_EN
    chk({name, "_ex"}, longint'($signed(o_ex)), ex);
`else
    if (ex != 0) begin end
`endif
  endtask

  initial begin
    int lat;
    int acc;
    int cyc;
    rst = 1'b1; i_valid = 1'b0; i_x = '0; i_last = 1'b0;
    i_alpha = '0; i_inv_n = '0; i_ready = 1'b1;

    // reset state
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", longint'(o_ready), 0);
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_ex2",   longint'(o_ex2),   0);
    chk("rst_ovf",   longint'(o_ovf),   0);
`ifdef EX2_MEAN_EX_EN
    chk("rst_ex",    longint'(o_ex),    0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", longint'(o_ready), 1);
    @(posedge clk); #1;

    // x=1..16, alpha=0, inv=16: sum_sq=1496 -> 93, sum_x=136 -> 8
    ramp(0, 16);
    wait_res("ramp_a0", lat);
    check_res("ramp_a0", lat, 93, 8, 1'b0);
    consume();

    // alpha=1: compressed squares sum to 372 -> 23
    ramp(1, 16);
    wait_res("ramp_a1", lat);
    check_res("ramp_a1", lat, 23, 8, 1'b0);
    consume();

    // x=-256 x4, inv=64: 262144*64>>8 saturates to 255, -1024*64>>>8=-256 -> -128
    for (int i = 0; i < 4; i++) send(-256, (i == 3), 0, 64);
    drop();
    wait_res("neg_sat", lat);
    check_res("neg_sat", lat, 255, -128, 1'b1);
    consume();

    // single sample -3, inv=255: 9*255>>8=8, -765>>>8=-3
    send(-3, 1'b1, 0, 255);
    drop();
    wait_res("single", lat);
    check_res("single", lat, 8, -3, 1'b0);
    consume();

    // operands latched on the first sample: alpha=2/inv=128 govern both
    // samples -> (1+1)*128>>8 = 1, 8*128>>8 = 4
    send(4, 1'b0, 2, 128);
    send(4, 1'b1, 0, 0);
    drop();
    wait_res("latch", lat);
    check_res("latch", lat, 1, 4, 1'b0);
    consume();

    // consumer stalls for 5 cycles: result held, no samples taken
    i_ready = 1'b0;
    ramp(0, 16);
    wait_res("stall", lat);
    check_res("stall", lat, 93, 8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      i_valid = 1'b1; i_x = 9'd5; i_last = 1'b1;
      @(negedge clk);
      chk("stall_valid", longint'(o_valid), 1);
      chk("stall_ex2",   longint'(o_ex2),   93);
      chk("stall_ready", longint'(o_ready), 0);
    end
    @(posedge clk); #1;
    drop();
    i_ready = 1'b1;
    consume();

    // reset after 3 samples, then a clean vector of 2 x4, inv=64:
    // 16*64>>8 = 4, 8*64>>8 = 2
    for (int i = 0; i < 3; i++) send(7, 1'b0, 3, 200);
    drop();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(2, (i == 3), 0, 64);
    drop();
    wait_res("after_rst", lat);
    check_res("after_rst", lat, 4, 2, 1'b0);
    consume();

    // 70 samples of 1 offered without i_last, inv=4: vector closes at 64,
    // 64*4>>8 = 1 for both means
    i_valid = 1'b1; i_x = 9'd1; i_last = 1'b0; i_alpha = 2'd0; i_inv_n = 8'd4;
    acc = 0;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      if (o_valid) break;
      if (o_ready && i_valid) acc++;
      @(posedge clk); #1;
      if (acc >= 70) i_valid = 1'b0;
      cyc++;
    end
    chk("maxlen_valid",    longint'(o_valid), 1);
    chk("maxlen_accepted", acc, 64);
    chk("maxlen_ex2",      longint'(o_ex2), 1);
    chk("maxlen_ovf",      longint'(o_ovf), 0);
`ifdef EX2_MEAN_EX_EN
    chk("maxlen_ex",       longint'($signed(o_ex)), 1);
`endif
    @(posedge clk); #1;
    drop();
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ex2_mean_unit.md
EX2_MEAN_UNIT -- requirements
Module: ex2_mean_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 9, signed input sample width.
REQ-002 SHALL have parameter OUT_W, default 8, output result width.
REQ-003 SHALL have parameter INV_W, default 8, width of reciprocal-length operand.
REQ-004 SHALL have parameter INV_FRAC, default 8, fractional bits of i_inv_n (unsigned Q0.INV_FRAC).
REQ-005 SHALL have parameter MAX_LEN, default 64, maximum samples per vector.
REQ-006 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port i_valid  input  1  sample valid.
REQ-009 SHALL have port o_ready  output  1  unit accepts a sample this cycle.
REQ-010 SHALL have port i_x  input  DATA_W  two's-complement sample.
REQ-011 SHALL have port i_last  input  1  final sample of vector.
REQ-012 SHALL have port i_alpha  input  2  compression shift.
REQ-013 SHALL have port i_inv_n  input  INV_W  reciprocal of vector length.
REQ-014 SHALL have port o_valid  output  1  results valid.
REQ-015 SHALL have port i_ready  input  1  downstream accepts results.
REQ-016 SHALL have port o_ex2  output  OUT_W  unsigned mean of compressed squares.
REQ-017 SHALL have port o_ex  output  OUT_W  signed mean (present only with macro, REQ-034).
REQ-018 SHALL have port o_ovf  output  1  accumulator or output saturation occurred.

Function
REQ-019 SHALL accept a sample on each rising edge where i_valid && o_ready.
REQ-020 SHALL implement FSM states IDLE, ACCUM, SCALE, DONE.
REQ-021 IDLE->ACCUM on first accepted sample; ACCUM->SCALE on accepted sample with i_last; SCALE->DONE after one cycle; DONE->IDLE when i_ready.
REQ-022 SHALL assert o_ready only in IDLE and ACCUM.
REQ-023 SHALL latch i_alpha and i_inv_n on the first accepted sample of a vector; later changes within the vector ignored.
REQ-024 Compressed square per sample SHALL be (x*x) >> (2*alpha), unsigned, truncating.
REQ-025 Accumulator width SHALL be 2*DATA_W + clog2(MAX_LEN)+1; sum of squares and sum of x accumulated in parallel.
REQ-026 In SCALE, o_ex2 SHALL be (sum_sq * inv_n) >> INV_FRAC, truncated, saturated to 2^OUT_W-1.
REQ-027 o_ex SHALL be (sum_x * inv_n) >>> INV_FRAC, arithmetic, saturated to signed OUT_W range.
REQ-028 o_valid SHALL rise exactly 2 cycles after the edge accepting the last sample and stay high with stable outputs until i_ready.
REQ-029 When sample count reaches MAX_LEN without i_last, that sample SHALL be treated as last.
REQ-030 o_ovf SHALL be set if any output saturates; held with o_valid, cleared on the next vector start.
REQ-031 A single-sample vector (i_last on first sample) SHALL be legal and follow the same latency.

Reset
REQ-032 i_rst SHALL force IDLE, clear accumulators, count, latched operands, and drive o_valid=0, o_ex2=0, o_ex=0, o_ovf=0, o_ready=0 during reset, 1 the cycle after.
REQ-033 Reset mid-vector or in DONE SHALL discard the partial vector with no o_valid pulse.

Configuration
REQ-034 Macro EX2_MEAN_EX_EN: when defined, o_ex port, sum_x accumulator and mean path present; when undefined, port and logic absent, E[x^2] behaviour unchanged.

Structure
REQ-035 Package ex2_mean_pkg SHALL hold FSM state typedef and default-width constants.
REQ-036 Sub-module ex2_scale_sat SHALL implement multiply-by-inv_n, shift and saturate, instanced once per output path.

Verification
REQ-037 x=1..16, alpha=0, inv_n=16, back-to-back -> o_ex2=93, o_ex=8, o_ovf=0, o_valid 2 cycles after last.
REQ-038 Same x, alpha=1, inv_n=16 -> o_ex2=23 (sum 372).
REQ-039 x=-256 x4, alpha=0, inv_n=64 -> o_ex2=255, o_ex=-128, o_ovf=1.
REQ-040 i_ready held low 5 cycles in DONE -> outputs stable, o_ready=0, no samples accepted.
REQ-041 i_rst asserted after 3 of 8 samples, then new vector x=2 x4, inv_n=64 -> o_ex2=4, o_ex=2, no stale result.
REQ-042 70 samples x=1, no i_last, inv_n=4 -> result after 64th sample, o_ex2=1, o_ex=1.
